// File: rtl/dff_checker_pkg.sv
// Shared state encoding for the D flip-flop response checker.
package dff_checker_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CHECKING = 2'd2,
    ST_FAULT    = 2'd3
  } chk_state_e;

endpackage : dff_checker_pkg

// File: rtl/dff_checker_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/dff_checker.sv
// Response checker for a D flip-flop: predicts Q one cycle ahead from the
// D/clear stimulus and compares it against the observed Q and Q_BAR.
module dff_checker
  import dff_checker_pkg::*;
#(
  parameter int unsigned ERR_CNT_W    = 8,
  parameter int unsigned CHK_CNT_W    = 16,
  parameter int unsigned STICKY_FAULT = 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 DUT_CLR,
  input  logic                 DUT_D,
  input  logic                 DUT_Q,
  input  logic                 DUT_Q_BAR,
  input  logic                 CHK_EN,
  output logic                 ERR,
  output logic                 COMP_ERR,
  output logic                 FAULT,
  output logic [ERR_CNT_W-1:0] ERR_COUNT,
  output logic [CHK_CNT_W-1:0] CHK_COUNT,
  output logic [STATE_W-1:0]   STATE
);

  chk_state_e state_q, state_d;
  logic       exp_q, exp_d;
  logic       err_q, err_d;
  logic       comp_err_q, comp_err_d;
  logic       fault_q, fault_d;
  logic       compare;
  logic       capture;
  logic       mismatch;

  // Mismatch against the prediction captured at the previous edge.
  always_comb begin
    mismatch = (DUT_Q != exp_q) || (DUT_Q_BAR != ~exp_q);
  end

  // FSM next state, reference-model capture and registered pulse inputs.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    compare = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CHK_EN) begin
          capture = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED, ST_CHECKING: begin
        if (!CHK_EN) begin
          state_d = ST_IDLE;
        end else begin
          compare = 1'b1;
          capture = 1'b1;
          if (mismatch && (STICKY_FAULT != 0)) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_CHECKING;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A cleared flip-flop must read 0 at the next edge regardless of D.
    if (capture) begin
      exp_d = DUT_CLR ? DUT_D : 1'b0;
    end
    err_d      = compare && mismatch;
    comp_err_d = compare && (DUT_Q == DUT_Q_BAR);
    fault_d    = fault_q || err_d;
  end

  // Checker state registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= ST_IDLE;
      exp_q      <= 1'b0;
      err_q      <= 1'b0;
      comp_err_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      comp_err_q <= comp_err_d;
      fault_q    <= fault_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (CLK),
    .rst_n (CLR),
    .inc   (err_d),
    .count (ERR_COUNT)
  );

  sat_counter #(.W(CHK_CNT_W)) u_chk_cnt (
    .clk   (CLK),
    .rst_n (CLR),
    .inc   (compare),
    .count (CHK_COUNT)
  );

  assign ERR      = err_q;
  assign COMP_ERR = comp_err_q;
  assign FAULT    = fault_q;
  assign STATE    = state_q;

endmodule : dff_checker
